// File: rtl/mux_n_1_rr.sv
// N:1 registered mux, valid/ready per channel, manual or round-robin select.
// Optional packet lock on round-robin grants: define MUX_N_1_LOCK_EN.
module mux_n_1_rr #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
`ifdef MUX_N_1_LOCK_EN
  input  logic [N-1:0]   in_last,
  output logic           out_last,
`endif
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic          ld;
  logic          xfer;
  logic          gnt_vld;
  logic          rr_vld;
  logic [SW-1:0] gnt;
  logic [SW-1:0] rr_gnt;
  logic [SW-1:0] ptr;
  logic [SW-1:0] ptr_nxt;
`ifdef MUX_N_1_LOCK_EN
  logic          lock;
  logic [SW-1:0] lock_ch;
`endif

  assign ld = !out_valid || out_ready;

  // Scan backwards so the channel closest to ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    rr_gnt = '0;
    rr_vld = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (in_valid[idx]) begin
        rr_gnt = SW'(idx);
        rr_vld = 1'b1;
      end
    end
  end

  always_comb begin
    gnt     = sel;
    gnt_vld = 1'b0;
    if (!mode) begin
      if (int'(sel) < N)
        gnt_vld = in_valid[sel];
    end
`ifdef MUX_N_1_LOCK_EN
    else if (lock) begin
      gnt     = lock_ch;
      gnt_vld = in_valid[lock_ch];
    end
`endif
    else begin
      gnt     = rr_gnt;
      gnt_vld = rr_vld;
    end
  end

  assign xfer = rst_n && ld && gnt_vld;

  always_comb begin
    in_ready = '0;
    if (xfer)
      in_ready[gnt] = 1'b1;
  end

  assign ptr_nxt = (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
`ifdef MUX_N_1_LOCK_EN
      out_last  <= 1'b0;
      lock      <= 1'b0;
      lock_ch   <= '0;
`endif
    end else begin
      if (ld) begin
        if (xfer) begin
          out_data  <= in_data[int'(gnt)*W +: W];
          out_ch    <= gnt;
          out_valid <= 1'b1;
`ifdef MUX_N_1_LOCK_EN
          out_last  <= in_last[gnt];
`endif
        end else begin
          out_valid <= 1'b0;
        end
      end
      if (xfer && mode) begin
`ifdef MUX_N_1_LOCK_EN
        lock    <= !in_last[gnt];
        lock_ch <= gnt;
        if (in_last[gnt])
          ptr <= ptr_nxt;
`else
        ptr <= ptr_nxt;
`endif
      end
`ifdef MUX_N_1_LOCK_EN
      if (!mode)
        lock <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_mux_n_1_rr.sv
// Scoreboard bench for mux_n_1_rr: directed scenarios then random traffic.
// Reference model tracks grants from the arbitration rules directly.
module tb_mux_n_1_rr;

  localparam int N  = 4;
  localparam int W  = 1;
  localparam int SW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           mode = 1'b0;
  logic           out_ready = 1'b0;
  logic [SW-1:0]  sel = '0;
  logic [N*W-1:0] in_data = '0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
`ifdef MUX_N_1_LOCK_EN
  logic [N-1:0]   in_last = '0;
  logic           out_last;
`endif

  always #5 clk = ~clk;

  mux_n_1_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef MUX_N_1_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int npass = 0;
  int ntot  = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [W-1:0] d;
    int           ch;
    logic         l;
  } beat_t;

  beat_t        q[$];
  int           chlog[$];
  logic [W-1:0] dlog[$];
  int           mptr = 0;
`ifdef MUX_N_1_LOCK_EN
  bit           mlock = 0;
  int           mlch = 0;
`endif

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Pack the first n logged entries, earliest in the top nibble.
  function automatic logic [63:0] seq(int n, bit dat);
    logic [63:0] s;
    s = '0;
    for (int i = 0; i < n; i++) begin
      s = s << 4;
      if (i >= chlog.size()) s[3:0] = 4'hf;
      else if (dat) s[3:0] = 4'(dlog[i]);
      else s[3:0] = 4'(chlog[i]);
    end
    return s;
  endfunction

  // Reference model: decides the grant for the coming edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      mptr = 0;
`ifdef MUX_N_1_LOCK_EN
      mlock = 0;
`endif
    end else begin
      int g;
      bit ld;
      logic [N-1:0] er;
      beat_t b;
      chk("out_valid", out_valid, q.size() != 0);
      ld = (q.size() == 0) || out_ready;
      g = -1;
      if (!mode) begin
        if (int'(sel) < N && in_valid[sel]) g = int'(sel);
      end
`ifdef MUX_N_1_LOCK_EN
      else if (mlock) begin
        if (in_valid[mlch]) g = mlch;
      end
`endif
      else g = rr_pick(in_valid, mptr);
      er = '0;
      if (ld && g >= 0) er[g] = 1'b1;
      chk("in_ready", in_ready, er);
      if (ld && g >= 0) begin
        b.d  = in_data[g*W +: W];
        b.ch = g;
        b.l  = 1'b0;
`ifdef MUX_N_1_LOCK_EN
        b.l = in_last[g];
`endif
        q.push_back(b);
        if (mode) begin
`ifdef MUX_N_1_LOCK_EN
          if (in_last[g]) begin
            mlock = 0;
            mptr = (g + 1) % N;
          end else begin
            mlock = 1;
            mlch = g;
          end
`else
          mptr = (g + 1) % N;
`endif
        end
      end
`ifdef MUX_N_1_LOCK_EN
      if (!mode) mlock = 0;
`endif
    end
  end

  // Monitor: compares each beat as the consumer takes it.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst_n && out_valid && out_ready) begin
      chk("beat_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        beat_t e;
        e = q.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_ch", out_ch, e.ch);
`ifdef MUX_N_1_LOCK_EN
        chk("out_last", out_last, e.l);
`endif
      end
      chlog.push_back(int'(out_ch));
      dlog.push_back(out_data);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    mode = 1'b1;
    in_valid = '1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_in_ready", in_ready, 0);
    in_valid = '0;
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick();
    chlog.delete();
    dlog.delete();
  endtask

  initial begin
    tick();
    do_reset();

    // Manual select
    mode = 1'b0;
    out_ready = 1'b1;
    in_data = 4'b1100;
    in_valid = 4'hf;
    for (int s = 0; s < 4; s++) begin
      sel = SW'(s);
      tick();
    end
    in_valid = '0;
    tick(3);
    chk("t1_ch", seq(4, 0), 64'h0123);
    chk("t1_data", seq(4, 1), 64'h0011);

    // Round-robin fairness
    do_reset();
    mode = 1'b1;
    in_valid = 4'hf;
    repeat (8) begin
      in_data = N'($urandom);
      tick();
    end
    in_valid = '0;
    tick(3);
    chk("t2_ch", seq(8, 0), 64'h01230123);

    // Sparse requesters
    chlog.delete();
    dlog.delete();
    in_valid = 4'b1010;
    repeat (4) begin
      in_data = N'($urandom);
      tick();
      chk("t3_rdy02", in_ready & 4'b0101, 0);
    end
    in_valid = '0;
    tick(3);
    chk("t3_ch", seq(4, 0), 64'h1313);

    // Backpressure
    do_reset();
    mode = 1'b1;
    in_valid = 4'hf;
    in_data = N'($urandom) | 4'b0001;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = N'($urandom);
      #1;
      chk("t4_hold_vld", out_valid, 1);
      chk("t4_hold_data", out_data, 1);
      chk("t4_hold_ch", out_ch, 0);
      chk("t4_hold_rdy", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("t4_next_rdy", in_ready, 4'b0010);
    tick();
    in_valid = '0;
    tick(3);
    chk("t4_ch", seq(2, 0), 64'h01);

    // Reset mid-stream with ptr at 2
    do_reset();
    mode = 1'b1;
    in_valid = 4'hf;
    in_data = N'($urandom);
    tick(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_vld", out_valid, 0);
    chlog.delete();
    dlog.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    tick(2);
    in_valid = '0;
    tick(3);
    chk("t5_ch", seq(2, 0), 64'h01);

`ifdef MUX_N_1_LOCK_EN
    // Packet lock on ch2 while ch0 and ch3 also request
    do_reset();
    mode = 1'b1;
    in_last = 4'b0000;
    in_valid = 4'b0100;
    tick();
    in_valid = 4'b1101;
    tick();
    in_last = 4'b0100;
    tick();
    in_last = 4'b1111;
    tick();
    in_valid = '0;
    tick(3);
    chk("t6_ch", seq(4, 0), 64'h2223);
`endif

    // Random traffic
    do_reset();
    repeat (400) begin
      mode = ($urandom % 4) != 0;
      sel = SW'($urandom);
      in_valid = N'($urandom);
      in_data = N'($urandom);
      out_ready = ($urandom % 4) != 0;
`ifdef MUX_N_1_LOCK_EN
      in_last = N'($urandom);
`endif
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    tick(3);
    chk("drain", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
